pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register, the successor to our fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed payload of WIDTH bits between two pipeline stages with valid/ready flow control, a synchronous flush that inserts a bubble, and an optional 2-entry skid buffer. The skid buffer gives full throughput with a registered ready. Each stage boundary in the core instantiates one copy, with its own WIDTH and CTRL_W.

## Interface
- WIDTH, 32: payload width in bits; must be ≥ 1.
- CTRL_W, 4: number of low payload bits that are control (RegWrite, MemWrite, …); 0 ≤ CTRL_W ≤ WIDTH. These bits are zeroed on flush.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous bubble insert; discards all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  held entry presented downstream.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  head payload; driven directly from the main register.
- count  out  2  held entries (0..2).

## Operation
- Accept = in_valid & in_ready.
- Pop = out_valid & out_ready.
- Storage: main register (head, drives out_data) plus skid register (skid mode only).
- States: EMPTY (count 0), ONE (main valid), TWO (main and skid valid; skid mode only).
- EMPTY: accept → ONE, main←in_data; otherwise stay.
- ONE, accept & pop → ONE, main←in_data.
- ONE, accept only → TWO, skid←in_data.
- ONE, pop only → EMPTY.
- ONE, neither → hold.
- TWO: in_ready=0. Pop → ONE, main←skid. No pop → hold everything.
- FIFO order always preserved; there is no path where the skid entry overtakes main.
- Without pop, out_data is stable while out_valid=1.
- flush (rst=0): next state EMPTY, count 0, out_valid 0. Bits [CTRL_W-1:0] of main and skid ←0; upper payload bits hold. Any accept or pop in the flush cycle is discarded or ignored.
- rst: all state, main, skid ←0. rst overrides flush.
- Reset values: out_valid=0, out_data=0, count=0, in_ready=1.
- in_valid while in_ready=0: no effect. Upstream must hold in_data.
- CTRL_W=0: flush clears valid only. CTRL_W=WIDTH: the whole payload is cleared.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput: 1 entry/cycle sustained while out_ready=1, in both modes.
- Skid mode: in_ready is a flop output (state≠TWO). There is no combinational path out_ready→in_ready.
- Non-skid mode: in_ready = ~out_valid | out_ready, a combinational path from out_ready.
- out_valid, out_data and count are always registered.
- Flush takes effect at the next edge: out_valid=0 in the cycle after flush is sampled high.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined: skid register and TWO state present. count reaches 2. in_ready is registered.
- PIPE_STAGE_REG_SKID_EN undefined: no skid storage; states EMPTY/ONE only. count ≤ 1. in_ready is combinational as above. Handshake semantics and latency are otherwise identical.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, out_data=0, count=0, in_ready=1 throughout. The first entry is accepted only after rst falls.
- Streaming: out_ready=1; push 0x1,0x2,…,0x10 back-to-back → outputs 0x1..0x10 in order, one per cycle, 1-cycle latency, in_ready never low.
- Backpressure (skid): push 0xA,0xB with out_ready=0 → count=2, in_ready=0, out_data=0xA held. Raise out_ready → 0xA, then 0xB, then out_valid=0. No loss or duplication. Non-skid build: count stops at 1 and in_ready tracks out_ready.
- Flush: WIDTH=8, CTRL_W=4; hold 0x5F and 0x3C (count=2), pulse flush with in_valid=1, in_data=0x77 → next cycle out_valid=0, count=0, main=0x50; 0x77 is not stored.
- Simultaneous events: in ONE, same-cycle accept+pop → count stays 1 and out_data becomes the new data. rst and flush together → all outputs at reset values.
- Random: constrained-random valid/ready with occasional flush vs. a reference queue model → ordering and count always match the model, and in_ready=0 whenever count=2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  // Flush keeps only the payload bits above the control field.
  localparam logic [WIDTH-1:0] keep_mask = ~((WIDTH'(1) << CTRL_W) - WIDTH'(1));
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state;
  logic [WIDTH-1:0] main;
  logic accept, pop;
  assign out_valid = state != EMPTY;
  assign out_data  = main;
  assign count     = state;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid;
  assign in_ready = state != TWO;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
      main  <= main & keep_mask;
      skid  <= skid & keep_mask;
    end else if (state == EMPTY) begin
      if (accept) begin
        state <= ONE;
        main  <= in_data;
      end
    end else if (state == TWO) begin
      if (pop) begin
        state <= ONE;
        main  <= skid;
      end
    end else if (accept && !pop) begin
      state <= TWO;
      skid  <= in_data;
    end else if (pop) begin
      if (accept) main <= in_data;
      else state <= EMPTY;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main  <= '0;
    end else if (flush) begin
      state <= EMPTY;
      main  <= main & keep_mask;
    end else if (accept) begin
      state <= ONE;
      main  <= in_data;
    end else if (pop) begin
      state <= EMPTY;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model scoreboard for pipe_stage_reg (WIDTH=8, CTRL_W=4), either skid build.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit skid = 1'b1;
`else
  localparam bit skid = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b1, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [7:0] in_data = 8'hEF, out_data;
  logic [1:0] count;
  logic [7:0] q[$];
  logic exp_rdy = 1'b1;
  int n_chk = 0, n_fail = 0;

  pipe_stage_reg #(.WIDTH(8), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Driver: records every accepted payload in the expected queue.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [7:0] d, input logic o);
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #3;
    if (!r && !f && v && exp_rdy) q.push_back(d);
  endtask

  // Monitor: compares the DUT against the queue, then retires popped entries.
  initial forever begin
    @(negedge clk);
    #2;
    exp_rdy = skid ? (q.size() < 2) : (q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    if (rst || flush) q.delete();
    else if (q.size() != 0 && out_ready) void'(q.pop_front());
  end

  initial begin
    repeat (2) begin
      cyc(1, 0, 1, 8'hEF, 0);
      chk("reset_data", out_data, 0);
    end
    for (int i = 1; i <= 16; i++) cyc(0, 0, 1, 8'(i), 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'h0A, 0);
    cyc(0, 0, 1, 8'h0B, 0);
    cyc(0, 0, 1, 8'h0B, 0);
    cyc(0, 0, 1, 8'h0B, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'h5F, 0);
    cyc(0, 0, 1, 8'h3C, 0);
    cyc(0, 1, 1, 8'h77, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flush_main", out_data, 8'h50);
    cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h22, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 1, 8'h33, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_flush_data", out_data, 0);
    for (int i = 0; i < 3000; i++)
      cyc(0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
